// File: rtl/floating_point_multiplier_seq.sv
// Iterative radix-2 shift-add floating point multiplier, {sign|exp|frac} format,
// subnormals flushed to zero, valid/ready on both sides, one operation in flight.
module floating_point_multiplier_seq #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_a_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] fp_b_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam int P  = FRAC_WIDTH + 1;
    localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int EW = EXP_WIDTH + 2;
    localparam int CW = $clog2(P + 1);

    localparam logic signed [EW-1:0] BIAS_S = EW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((2 ** EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S = '0;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [P-1:0]           mcand_q, mplier_q;
    logic [2*P-1:0]         acc_q;
    logic signed [EW-1:0]   e_q;
    logic                   sign_q, za_q, zb_q, ia_q, ib_q;

    logic [EXP_WIDTH-1:0]   ea, eb;
    logic                   za, zb;
    logic [2*P-1:0]         addend;
    logic [FRAC_WIDTH-1:0]  nfrac, rfrac;
    logic [FRAC_WIDTH:0]    rsum;
    logic                   guard;
    logic signed [EW-1:0]   ne;
    logic [W-1:0]           res_d;

    assign ea         = fp_a_i[W-2:FRAC_WIDTH];
    assign eb         = fp_b_i[W-2:FRAC_WIDTH];
    assign za         = (ea == '0);
    assign zb         = (eb == '0);
    assign addend     = {{P{1'b0}}, mcand_q};
    assign in_ready_o = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = MUL;
            MUL:     if (cnt_q == CW'(P - 1)) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_valid_o && out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Normalise on the product's top bit, round half-up, then saturate and apply specials.
    always_comb begin
        nfrac = '0;
        guard = 1'b0;
        ne    = e_q;
        if (acc_q[2*P-1]) begin
            nfrac = acc_q[2*P-2:P];
            guard = acc_q[P-1];
            ne    = e_q + ONE_S;
        end else begin
            nfrac = acc_q[2*P-3:P-1];
            guard = acc_q[P-2];
        end
        rsum  = {1'b0, nfrac} + (FRAC_WIDTH + 1)'(guard);
        rfrac = rsum[FRAC_WIDTH-1:0];
        if (rsum[FRAC_WIDTH]) ne = ne + ONE_S;

        if (ne >= EMAX_S)      res_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        else if (ne <= ZERO_S) res_d = {sign_q, {(W-1){1'b0}}};
        else                   res_d = {sign_q, ne[EXP_WIDTH-1:0], rfrac};

        if ((za_q || zb_q) && (ia_q || ib_q)) res_d = {sign_q, {(W-1){1'b1}}};
        else if (ia_q || ib_q)                res_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        else if (za_q || zb_q)                res_d = {sign_q, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            za_q        <= 1'b0;
            zb_q        <= 1'b0;
            ia_q        <= 1'b0;
            ib_q        <= 1'b0;
            fp_o        <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    sign_q   <= fp_a_i[W-1] ^ fp_b_i[W-1];
                    za_q     <= za;
                    zb_q     <= zb;
                    ia_q     <= (ea == '1);
                    ib_q     <= (eb == '1);
                    mcand_q  <= za ? '0 : {1'b1, fp_a_i[FRAC_WIDTH-1:0]};
                    mplier_q <= zb ? '0 : {1'b1, fp_b_i[FRAC_WIDTH-1:0]};
                    e_q      <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                end
                MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + (addend << cnt_q);
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                NORM: fp_o <= res_d;
                // out_valid_o rises one cycle into DONE, giving a fixed P+2 accept-to-valid latency.
                DONE: begin
                    if (!out_valid_o)     out_valid_o <= 1'b1;
                    else if (out_ready_i) out_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_multiplier_seq.sv
// Self-checking bench for floating_point_multiplier_seq (binary32 configuration).
module tb_floating_point_multiplier_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] fp_a_i = '0, fp_b_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] fp_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    floating_point_multiplier_seq #(.EXP_WIDTH(8), .FRAC_WIDTH(23)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fp_a_i(fp_a_i), .fp_b_i(fp_b_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fp_o(fp_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s, za, zb, ia, ib, g;
        logic [7:0] ea, eb;
        logic [23:0] ma, mb, rs;
        logic [47:0] prod;
        logic [22:0] fr;
        int e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        za = (ea == 8'd0); zb = (eb == 8'd0);
        ia = (ea == 8'hFF); ib = (eb == 8'hFF);
        ma = za ? 24'd0 : {1'b1, a[22:0]};
        mb = zb ? 24'd0 : {1'b1, b[22:0]};
        prod = 48'(ma) * 48'(mb);
        e = int'(ea) + int'(eb) - 127;
        if (prod[47]) begin fr = prod[46:24]; g = prod[23]; e = e + 1; end
        else          begin fr = prod[45:23]; g = prod[22]; end
        rs = {1'b0, fr} + 24'(g);
        if (rs[23]) e = e + 1;
        fr = rs[22:0];
        if ((za || zb) && (ia || ib)) return {s, 8'hFF, 23'h7FFFFF};
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, e[7:0], fr};
    endfunction

    // Presents operands and pushes the expected product at the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        int n = 0;
        @(negedge clk_i);
        while (!in_ready_o && n < 200) begin @(negedge clk_i); n++; end
        fp_a_i = a; fp_b_i = b; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        exp_q.push_back(expv);
    endtask

    // Waits (bounded) for out_valid_o, returns value and latency in edges since accept, then handshakes.
    task automatic collect(output logic [31:0] val, output int lat, output bit ok);
        ok = 1'b0; lat = 0; val = '0;
        out_ready_i = 1'b0;
        while (lat < 100) begin
            @(posedge clk_i); #1; lat++;
            if (out_valid_o) begin ok = 1'b1; break; end
        end
        val = fp_o;
        @(negedge clk_i) out_ready_i = 1'b1;
        @(posedge clk_i); #1 out_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
        tests++; if (fp_o !== 32'h0) begin fails++; $display("FAIL reset_fp_o got=%h want=00000000", fp_o); end
        tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_pair(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] want, input bit check_lat);
        logic [31:0] v, e; int lat; bit ok;
        issue(a, b, want);
        collect(v, lat, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        tests++; if (!ok) begin fails++; $display("FAIL %s_timeout got=no_valid want=valid", name); end
        tests++; if (v !== e) begin fails++; $display("FAIL %s got=%h want=%h", name, v, e); end
        if (check_lat) begin
            tests++; if (lat !== 26) begin fails++; $display("FAIL %s_latency got=%0d want=26", name, lat); end
        end
        tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL %s_valid_drop got=%b want=0", name, out_valid_o); end
    endtask

    task automatic test_basic;
        test_pair("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
    endtask

    task automatic test_rounding;
        test_pair("round_carry", 32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 1'b1);
        test_pair("round_up",    32'h3F800001, 32'h3FC00000, ref_mul(32'h3F800001, 32'h3FC00000), 1'b0);
    endtask

    task automatic test_saturation;
        test_pair("overflow",  32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0);
        test_pair("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0);
    endtask

    task automatic test_specials;
        test_pair("zero_x_inf", 32'h80000000, 32'h7F800000, 32'hFFFFFFFF, 1'b1);
        test_pair("subnormal",  32'h00400000, 32'h3F800000, 32'h00000000, 1'b0);
        test_pair("inf_x_neg",  32'hC0000000, 32'h7F800000, 32'hFF800000, 1'b0);
        test_pair("zero_x_neg", 32'h00000000, 32'hC0400000, 32'h80000000, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [31:0] e; int n = 0; bit stable = 1'b1, blocked = 1'b1, quiet = 1'b1;
        issue(32'h40400000, 32'h40400000, 32'h41100000);
        out_ready_i = 1'b0;
        while (!out_valid_o && n < 100) begin @(posedge clk_i); #1; n++; end
        tests++; if (!out_valid_o) begin fails++; $display("FAIL bp_timeout got=no_valid want=valid"); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            in_valid_i = ~in_valid_i; fp_a_i = $urandom; fp_b_i = $urandom;
            if (fp_o !== e || out_valid_o !== 1'b1) stable = 1'b0;
            if (in_ready_o !== 1'b0) blocked = 1'b0;
        end
        @(negedge clk_i);
        if (fp_o !== e || out_valid_o !== 1'b1) stable = 1'b0;
        tests++; if (!stable) begin fails++; $display("FAIL bp_stable got=%h want=%h", fp_o, e); end
        tests++; if (!blocked) begin fails++; $display("FAIL bp_in_ready got=1 want=0"); end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(posedge clk_i); #1 out_ready_i = 1'b0;
        repeat (35) begin @(negedge clk_i); if (out_valid_o) quiet = 1'b0; end
        tests++; if (!quiet) begin fails++; $display("FAIL bp_no_new_op got=valid want=idle"); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v, e; int lat; bit ok, quiet = 1'b1;
        issue(32'h40E00000, 32'h40A00000, 32'h420C0000);
        repeat (10) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        tests++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            fails++; $display("FAIL rst_mid_abort got=%b%b want=01", out_valid_o, in_ready_o); end
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (30) begin @(negedge clk_i); if (out_valid_o) quiet = 1'b0; end
        tests++; if (!quiet) begin fails++; $display("FAIL rst_mid_spurious got=valid want=idle"); end
        issue(32'h3FC00000, 32'h40000000, 32'h40400000);
        collect(v, lat, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        tests++; if (!ok || v !== e) begin fails++; $display("FAIL rst_mid_result got=%h want=%h", v, e); end
        tests++; if (lat !== 26) begin fails++; $display("FAIL rst_mid_latency got=%0d want=26", lat); end
        quiet = 1'b1;
        repeat (40) begin @(negedge clk_i); if (out_valid_o) quiet = 1'b0; end
        tests++; if (!quiet) begin fails++; $display("FAIL rst_mid_once got=second_valid want=none", ); end
    endtask

    task automatic test_random;
        logic [31:0] a, b, v, e; int lat; bit ok;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            if (i % 4 != 3) begin
                a[30:23] = 8'($urandom_range(90, 165));
                b[30:23] = 8'($urandom_range(90, 165));
            end
            issue(a, b, ref_mul(a, b));
            collect(v, lat, ok);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            tests++; if (!ok || v !== e) begin fails++; $display("FAIL random_%0d a=%h b=%h got=%h want=%h", i, a, b, v, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_specials();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
